// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the key schedule and round datapath.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam int         AES_KW    = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SUB,
    ST_EXPAND,
    ST_DONE
  } ks_state_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox_client.sv
// Serialises four S-box byte lookups (MSB first) over the req/vld handshake into one SubWord.
// 2 cycles per byte with a zero-wait S-box; o_done pulses with the last response, o_word valid the cycle after.
module aes_sbox_client
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  word_t      i_word,
  output logic       o_sbox_req,
  output logic [7:0] o_sbox_addr,
  input  logic       i_sbox_vld,
  input  logic [7:0] i_sbox_data,
  output word_t      o_word,
  output logic       o_done
);

  logic [1:0] r_cnt;
  word_t      r_src;
  word_t      r_sub;
  logic       r_req;
  logic       w_ack;

  // A response only counts while a request is pending; strays are dropped.
  assign w_ack = r_req & i_sbox_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_src <= '0;
      r_sub <= '0;
      r_req <= 1'b0;
    end else if (i_start) begin
      r_cnt <= 2'd0;
      r_src <= i_word;
      r_req <= 1'b1;
    end else if (w_ack) begin
      r_sub <= {r_sub[23:0], i_sbox_data};
      if (r_cnt == 2'd3) begin
        r_req <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 2'd1;
        r_src <= {r_src[23:0], 8'h00};
      end
    end
  end

  assign o_sbox_req  = r_req;
  assign o_sbox_addr = r_src[31:24];
  assign o_word      = r_sub;
  assign o_done      = w_ack & (r_cnt == 2'd3);

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands a latched key into NR+1 round keys held in a buffer read by index.
// key_ready 92 cycles after start with a zero-wait S-box; stalls on S-box response delay; rk_out 1-cycle read.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key,
  output logic          busy,
  output logic          key_ready,
  output logic          sbox_req,
  output logic [7:0]    sbox_addr,
  input  logic          sbox_vld,
  input  logic [7:0]    sbox_data,
  input  logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_out
);

  localparam logic [3:0] NR_L = 4'(NR);

  ks_state_t   r_state;
  ks_state_t   w_state_nxt;
  rkey_t       r_key;
  rkey_t       r_w;
  logic [3:0]  r_round;
  logic [7:0]  r_rcon;
  logic        r_busy;
  logic        r_key_ready;
  rkey_t       r_rk_out;
  rkey_t       r_buf [0:NR];

  logic        w_accept;
  logic        w_load;
  logic        w_expand;
  logic        w_sub_start;
  word_t       w_sub_word;
  word_t       w_sub;
  logic        w_sub_done;
  word_t       w_n0;
  word_t       w_n1;
  word_t       w_n2;
  word_t       w_n3;
  rkey_t       w_next;
  logic        w_buf_we;
  logic [3:0]  w_buf_widx;
  rkey_t       w_buf_wdat;

  assign w_accept = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  assign w_n0   = r_w[127:96] ^ w_sub ^ {r_rcon, 24'h0};
  assign w_n1   = w_n0 ^ r_w[95:64];
  assign w_n2   = w_n1 ^ r_w[63:32];
  assign w_n3   = w_n2 ^ r_w[31:0];
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The next SubWord is launched from LOAD/EXPAND so the first request is up in the first SUB cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_expand    = 1'b0;
    w_sub_start = 1'b0;
    w_sub_word  = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_sub_start = 1'b1;
        w_sub_word  = rot_word(r_key[31:0]);
        w_state_nxt = ST_SUB;
      end
      ST_SUB: begin
        if (w_sub_done) w_state_nxt = ST_EXPAND;
      end
      ST_EXPAND: begin
        w_expand = 1'b1;
        if (r_round < NR_L) begin
          w_sub_start = 1'b1;
          w_sub_word  = rot_word(w_n3);
          w_state_nxt = ST_SUB;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key       <= '0;
      r_w         <= '0;
      r_round     <= 4'd0;
      r_rcon      <= RCON_INIT;
      r_busy      <= 1'b0;
      r_key_ready <= 1'b0;
      r_rk_out    <= '0;
    end else begin
      r_busy <= (w_state_nxt == ST_LOAD) | (w_state_nxt == ST_SUB) | (w_state_nxt == ST_EXPAND);
      if (w_accept) begin
        r_key       <= key;
        r_key_ready <= 1'b0;
      end else if (r_state == ST_DONE) begin
        r_key_ready <= 1'b1;
      end
      if (w_load) begin
        r_w     <= r_key;
        r_round <= 4'd1;
        r_rcon  <= RCON_INIT;
      end else if (w_expand) begin
        r_w     <= w_next;
        r_round <= r_round + 4'd1;
        r_rcon  <= xtime(r_rcon);
      end
      r_rk_out <= (r_key_ready && (rk_idx <= NR_L)) ? r_buf[rk_idx] : '0;
    end
  end

  assign w_buf_we   = w_load | w_expand;
  assign w_buf_widx = w_load ? 4'd0 : r_round;
  assign w_buf_wdat = w_load ? r_key : w_next;

  // Round-key storage carries no reset; reads are gated by key_ready instead.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_buf_widx] <= w_buf_wdat;
  end

  aes_sbox_client u_sbox_client (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_sub_start),
    .i_word      (w_sub_word),
    .o_sbox_req  (sbox_req),
    .o_sbox_addr (sbox_addr),
    .i_sbox_vld  (sbox_vld),
    .i_sbox_data (sbox_data),
    .o_word      (w_sub),
    .o_done      (w_sub_done)
  );

  assign busy      = r_busy;
  assign key_ready = r_key_ready;
  assign rk_out    = r_rk_out;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: S-box memory with programmable delay, FIPS-197 schedule model, per-cycle rk_out compare.
module tb_aes_key_expand;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         key_ready;
  logic         sbox_req;
  logic [7:0]   sbox_addr;
  logic         sbox_vld;
  logic [7:0]   sbox_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int           errors = 0;
  int           checks = 0;
  logic [7:0]   sbox [256];
  logic [127:0] exp_rk [11];
  bit           cmp_en = 1'b0;
  int           mem_dmax = 0;
  bit           stray = 1'b0;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .key_ready (key_ready),
    .sbox_req  (sbox_req),
    .sbox_addr (sbox_addr),
    .sbox_vld  (sbox_vld),
    .sbox_data (sbox_data),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented FIPS-197 key expansion over w[0..43].
  task automatic set_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // S-box memory: one request at a time, answers 1+delay cycles after it first sees req.
  initial begin : sbox_mem
    bit         pend;
    int         cnt;
    logic [7:0] paddr;
    logic       nv;
    logic [7:0] nd;
    pend = 1'b0; cnt = 0; paddr = 8'h00;
    sbox_vld = 1'b0; sbox_data = 8'h00;
    forever begin
      @(negedge clk);
      nv = 1'b0; nd = 8'h00;
      if (rst === 1'b1) begin
        pend = 1'b0;
      end else if (stray) begin
        nv = 1'b1; nd = 8'ha5;
      end else if (sbox_vld) begin
        if (pend) begin
          chk("sbox_hold_at_vld", {119'b0, sbox_req, sbox_addr}, {119'b0, 1'b1, paddr});
          pend = 1'b0;
        end
      end else begin
        if (pend) begin
          chk("sbox_hold_wait", {119'b0, sbox_req, sbox_addr}, {119'b0, 1'b1, paddr});
        end else if (sbox_req === 1'b1) begin
          pend = 1'b1; paddr = sbox_addr; cnt = $urandom_range(mem_dmax, 0);
        end
        if (pend) begin
          if (cnt == 0) begin nv = 1'b1; nd = sbox[paddr]; end
          else cnt--;
        end
      end
      @(posedge clk); #1;
      sbox_vld = nv; sbox_data = nd;
    end
  end

  // rk_out must be the model's round key for last cycle's index while ready, else zero.
  initial begin : compare
    bit           prdy;
    bit           prst;
    logic [3:0]   pidx;
    logic [127:0] e;
    prdy = 1'b0; prst = 1'b1; pidx = 4'd0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e = (!prst && prdy && pidx <= 4'd10) ? exp_rk[pidx] : '0;
        chk($sformatf("rk_out[%0d]", pidx), rk_out, e);
      end
      prdy = (key_ready === 1'b1);
      pidx = rk_idx;
      prst = (rst === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    key = k; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_key(input logic [127:0] k, input bit chk_lat, input int restart_at,
                         input logic [127:0] k2);
    int n;
    cmp_en = 1'b0;
    set_model(k);
    pulse_start(k);
    chk("busy_after_start", {127'b0, busy}, 128'd1);
    chk("key_ready_cleared", {127'b0, key_ready}, 128'd0);
    n = 0;
    while (key_ready !== 1'b1 && n < 3000) begin
      if (n == restart_at) begin key = k2; start = 1'b1; end
      tick();
      start = 1'b0;
      n++;
      cmp_en = 1'b1;
    end
    if (key_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: key_ready still %b after %0d cycles", key_ready, n);
    end else if (chk_lat) begin
      chk("ready_latency", 128'(n), 128'd92);
    end
    chk("busy_when_ready", {127'b0, busy}, 128'd0);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      tick();
    end
    tick();
  endtask

  task automatic rd(input logic [3:0] idx, output logic [127:0] v);
    rk_idx = idx;
    tick();
    v = rk_out;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [127:0] v;
    rst = 1'b1; start = 1'b0; key = '0; rk_idx = 4'd0;
    build_sbox();
    repeat (3) tick();
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_key_ready", {127'b0, key_ready}, 128'd0);
    chk("rst_sbox_req", {127'b0, sbox_req}, 128'd0);
    chk("rst_sbox_addr", {120'b0, sbox_addr}, 128'd0);
    chk("rst_rk_out", rk_out, 128'd0);
    rst = 1'b0;
    tick();

    set_model(FIPS_KEY);
    chk("model_fips_rk0", exp_rk[0], FIPS_KEY);
    chk("model_fips_rk1", exp_rk[1], FIPS_RK1);
    chk("model_fips_rk10", exp_rk[10], FIPS_RK10);
    set_model('0);
    chk("model_zero_rk1", exp_rk[1], ZERO_RK1);
    chk("model_zero_rk10", exp_rk[10], ZERO_RK10);

    stray = 1'b1; tick(); stray = 1'b0;
    repeat (3) tick();
    chk("idle_stray_busy", {127'b0, busy}, 128'd0);
    chk("idle_stray_req", {127'b0, sbox_req}, 128'd0);
    chk("idle_stray_ready", {127'b0, key_ready}, 128'd0);

    run_key(FIPS_KEY, 1'b1, -1, '0);
    rd(4'd0, v);  chk("fips_rk0", v, FIPS_KEY);
    rd(4'd1, v);  chk("fips_rk1", v, FIPS_RK1);
    rd(4'd10, v); chk("fips_rk10", v, FIPS_RK10);
    sweep();

    mem_dmax = 5;
    run_key(FIPS_KEY, 1'b0, -1, '0);
    rd(4'd10, v); chk("fips_delay_rk10", v, FIPS_RK10);
    sweep();
    mem_dmax = 0;

    run_key('0, 1'b1, -1, '0);
    rd(4'd1, v);  chk("zero_rk1", v, ZERO_RK1);
    rd(4'd10, v); chk("zero_rk10", v, ZERO_RK10);
    sweep();

    run_key(FIPS_KEY, 1'b1, 40, ALT_KEY);
    rd(4'd10, v); chk("restart_ignored_rk10", v, FIPS_RK10);
    sweep();
    run_key(ALT_KEY, 1'b1, -1, '0);
    sweep();

    cmp_en = 1'b0;
    pulse_start(FIPS_KEY);
    repeat (29) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", {127'b0, busy}, 128'd0);
    chk("abort_sbox_req", {127'b0, sbox_req}, 128'd0);
    chk("abort_key_ready", {127'b0, key_ready}, 128'd0);
    chk("abort_rk_out", rk_out, 128'd0);
    rst = 1'b0;
    tick();
    stray = 1'b1; tick(); stray = 1'b0;
    repeat (3) tick();
    chk("abort_stray_busy", {127'b0, busy}, 128'd0);
    chk("abort_stray_req", {127'b0, sbox_req}, 128'd0);
    run_key(FIPS_KEY, 1'b1, -1, '0);
    rd(4'd1, v); chk("after_abort_rk1", v, FIPS_RK1);
    for (int i = 11; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("oob_rk%0d", i), v, 128'd0);
    end
    sweep();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
AES-128 key-schedule stage that sits directly upstream of the round datapath. It takes a 128-bit cipher key and produces all 11 round keys (round 0..10) into an internal round-key buffer, which the round datapath reads by index. SubWord bytes are fetched through the same byte-wide S-box request/response handshake used by the round datapath, so one shared S-box memory serves both blocks.

Parameters:
NR, 10, number of rounds; the buffer holds NR+1 round keys.
KW, 128, key and round-key width; fixed for AES-128.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that latches key and begins expansion
key  in  128  cipher key; key[127:120] is byte 0 (column-major, matching the state-matrix load order)
busy  out  1  high from the cycle after an accepted start until done
key_ready  out  1  high once all NR+1 round keys are valid; cleared by rst or by an accepted start
sbox_req  out  1  S-box lookup request; held high until sbox_vld
sbox_addr  out  8  S-box byte address; stable while sbox_req is high
sbox_vld  in  1  one-cycle response strobe from the S-box memory
sbox_data  in  8  S-box result, valid when sbox_vld is high
rk_idx  in  4  round-key read index, 0..NR
rk_out  out  128  round key at rk_idx, registered with 1-cycle latency

Behaviour:
- Reset values: busy=0, key_ready=0, sbox_req=0, sbox_addr=0, rk_out=0. The FSM returns to IDLE, the round counter is 0, and rcon=8'h01. Reset mid-expansion aborts immediately. A response arriving after the abort is ignored.
- start is accepted only in IDLE or DONE; it is ignored while busy=1.
- FSM states: IDLE -> LOAD -> SUB (4 lookups) -> EXPAND -> (round<NR ? SUB : DONE). DONE -> LOAD on an accepted start.
- LOAD (1 cycle):
  - w0..w3 = key[127:96], key[95:64], key[63:32], key[31:0].
  - Store the key as round key 0.
  - round=1, rcon=01, key_ready=0.
- SUB:
  - temp = RotWord(w3) = {w3[23:0], w3[31:24]}.
  - Byte j (j=0..3, MSB first) is fetched with sbox_addr = temp byte j and sbox_req=1, holding until the cycle sbox_vld=1. At that cycle, sub[j] <= sbox_data and sbox_req drops.
  - The next request asserts in the following cycle. Only one lookup is outstanding at any time.
  - An sbox_vld while sbox_req=0 is ignored.
- EXPAND (1 cycle):
  - n0 = w0 ^ {sub ^ {rcon, 24'h0}}, n1 = n0 ^ w1, n2 = n1 ^ w2, n3 = n2 ^ w3.
  - Write {n0,n1,n2,n3} to buffer[round]; w <= n.
  - rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0), giving 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - round++.
- DONE: busy=0 and key_ready=1; the buffer is held.
- Latency with a zero-wait S-box (sbox_vld in the cycle after sbox_req first rises):
  - 2 cycles per lookup, 9 cycles per round.
  - key_ready rises exactly 92 clk edges after the start edge: 1 for LOAD, 90 for the rounds, 1 for the DONE transition.
- Read port:
  - rk_out <= buffer[rk_idx] on every edge while key_ready=1.
  - rk_out <= 0 if rk_idx > NR or key_ready=0.
- Width rules: all XOR is 32-bit, xtime is 8-bit mod x^8+x^4+x^3+x+1, and round is a 4-bit counter.

Decomposition:
- Package aes_pkg:
  - AES_NR, AES_KW
  - typedef word_t [31:0], rkey_t [127:0]
  - the FSM state enum
  - function xtime
  - the RCON_INIT constant
- The round datapath imports the same package.
- One natural sub-module, aes_sbox_client: it serialises 4 byte lookups over the req/vld handshake and returns a 32-bit SubWord plus a done pulse. The round datapath can reuse it later.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with a zero-wait S-box model -> key_ready after 92 cycles; rk_idx=0 gives the key, rk_idx=1 gives a0fafe1788542cb123a339392a6c7605, rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key with random 0-5 cycle S-box response delays -> identical round keys; sbox_addr stays stable while sbox_req is high; never two outstanding requests.
- All-zero key -> rk_idx=1 gives 62636363626363636263636362636363; rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- Second start at cycle 40 mid-expansion -> ignored, and the result equals the first key's schedule. Then start with a new key in DONE -> key_ready drops the next cycle, and the new schedule is correct.
- rst asserted at cycle 30 -> the next cycle shows busy=0, sbox_req=0, key_ready=0, rk_out=0. A stray sbox_vld afterwards has no effect, and a subsequent start produces a correct schedule.
- rk_idx=11..15 after done -> rk_out=0. Spurious sbox_vld pulses in IDLE -> no state change.
